// File: rtl/fcart_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fcart_mem_arbiter
// Shares one byte-wide read-only memory between a CPU (PRG) port and a PPU
// (CHR) port. Each port holds one pending request (flag + address); a small
// IDLE/BUSY FSM grants one port at a time with round-robin on ties, holds the
// memory request until the memory acknowledges, then returns the byte to the
// granted port with a one-cycle ack pulse.
//
// Parameters
//   ADDR_W    shared memory address width
//   CHR_BASE  base address of the CHR region in shared memory
// Ports
//   CLK, RST               clock, asynchronous active-high reset
//   cpu_req/cpu_addr       PRG read request pulse and 15-bit byte address
//   cpu_data/cpu_ack       last PRG byte fetched, completion pulse
//   ppu_req/ppu_addr       CHR read request pulse and 13-bit byte address
//   ppu_data/ppu_ack       last CHR byte fetched, completion pulse
//   mem_req/mem_addr       shared memory request (level) and address
//   mem_rdata/mem_ack      shared memory read data and completion pulse
// -----------------------------------------------------------------------------
module fcart_mem_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned CHR_BASE = 32'h0000_8000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic [14:0]       cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_ack,
    input  logic              ppu_req,
    input  logic [12:0]       ppu_addr,
    output logic [7:0]        ppu_data,
    output logic              ppu_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        PORT_CPU = 1'b0,
        PORT_PPU = 1'b1
    } port_t;

    state_t            state_r;
    port_t             last_grant_r;
    port_t             cur_grant_r;
    logic              cpu_pend_r;
    logic              ppu_pend_r;
    logic [14:0]       cpu_addr_r;
    logic [12:0]       ppu_addr_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        cpu_data_r;
    logic [7:0]        ppu_data_r;
    logic              cpu_ack_r;
    logic              ppu_ack_r;

    logic              grant_any_s;
    port_t             grant_sel_s;
    logic [ADDR_W-1:0] cpu_map_s;
    logic [ADDR_W-1:0] ppu_map_s;
    logic [ADDR_W-1:0] grant_addr_s;

    // CPU addresses are zero-extended; CHR addresses are offset by CHR_BASE and
    // wrap modulo 2^ADDR_W.
    assign cpu_map_s = ADDR_W'(cpu_addr_r);
    assign ppu_map_s = ADDR_W'(CHR_BASE) + ADDR_W'(ppu_addr_r);

    // Round-robin port selection among the pending flags.
    always_comb begin
        grant_any_s = cpu_pend_r | ppu_pend_r;
        if (cpu_pend_r && ppu_pend_r) begin
            // Tie: favour whichever port was not served most recently.
            grant_sel_s = (last_grant_r == PORT_CPU) ? PORT_PPU : PORT_CPU;
        end else if (ppu_pend_r) begin
            grant_sel_s = PORT_PPU;
        end else begin
            grant_sel_s = PORT_CPU;
        end
    end

    // Memory address for the port about to be granted.
    always_comb begin
        case (grant_sel_s)
            PORT_CPU: grant_addr_s = cpu_map_s;
            PORT_PPU: grant_addr_s = ppu_map_s;
            default:  grant_addr_s = cpu_map_s;
        endcase
    end

    // Arbiter FSM, request capture and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            last_grant_r <= PORT_CPU;
            cur_grant_r  <= PORT_CPU;
            cpu_pend_r   <= 1'b0;
            ppu_pend_r   <= 1'b0;
            cpu_addr_r   <= 15'h0000;
            ppu_addr_r   <= 13'h0000;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            cpu_data_r   <= 8'h00;
            ppu_data_r   <= 8'h00;
            cpu_ack_r    <= 1'b0;
            ppu_ack_r    <= 1'b0;
        end else begin
            cpu_ack_r <= 1'b0;
            ppu_ack_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        state_r      <= ST_BUSY;
                        mem_req_r    <= 1'b1;
                        mem_addr_r   <= grant_addr_s;
                        cur_grant_r  <= grant_sel_s;
                        last_grant_r <= grant_sel_s;
                        if (grant_sel_s == PORT_PPU) begin
                            ppu_pend_r <= 1'b0;
                        end else begin
                            cpu_pend_r <= 1'b0;
                        end
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        case (cur_grant_r)
                            PORT_CPU: begin
                                cpu_data_r <= mem_rdata;
                                cpu_ack_r  <= 1'b1;
                            end
                            PORT_PPU: begin
                                ppu_data_r <= mem_rdata;
                                ppu_ack_r  <= 1'b1;
                            end
                            default: begin
                                cpu_data_r <= cpu_data_r;
                            end
                        endcase
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase

            // A new request wins over the grant-time clear above (later
            // non-blocking assignment), so a request arriving on the grant or
            // completion edge queues a fresh access. The granted access already
            // has its address in mem_addr_r, so overwriting here is harmless.
            if (cpu_req) begin
                cpu_pend_r <= 1'b1;
                cpu_addr_r <= cpu_addr;
            end
            if (ppu_req) begin
                ppu_pend_r <= 1'b1;
                ppu_addr_r <= ppu_addr;
            end
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign cpu_data = cpu_data_r;
    assign cpu_ack  = cpu_ack_r;
    assign ppu_data = ppu_data_r;
    assign ppu_ack  = ppu_ack_r;

endmodule

// File: doc/fcart_mem_arbiter.md
FCART_MEM_ARBITER -- requirements
Module: fcart_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: shared memory address width in bits.
REQ-002 SHALL have parameter CHR_BASE, default 'h8000: base address of the CHR region in shared memory.
REQ-003 SHALL have port CLK  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port cpu_req  input  1: one-cycle PRG read request pulse.
REQ-006 SHALL have port cpu_addr  input  15: PRG byte address, sampled with cpu_req.
REQ-007 SHALL have port cpu_data  output  8: last PRG byte fetched.
REQ-008 SHALL have port cpu_ack  output  1: one-cycle PRG completion pulse.
REQ-009 SHALL have port ppu_req  input  1: one-cycle CHR read request pulse.
REQ-010 SHALL have port ppu_addr  input  13: CHR byte address, sampled with ppu_req.
REQ-011 SHALL have port ppu_data  output  8: last CHR byte fetched.
REQ-012 SHALL have port ppu_ack  output  1: one-cycle CHR completion pulse.
REQ-013 SHALL have port mem_req  output  1: shared memory read request, level.
REQ-014 SHALL have port mem_addr  output  ADDR_W: shared memory address.
REQ-015 SHALL have port mem_rdata  input  8: shared memory read data, valid with mem_ack.
REQ-016 SHALL have port mem_ack  input  1: memory completion, one cycle.

Function
REQ-017 SHALL keep one pending flag plus address register per port; *_req high at an edge sets flag and stores address.
REQ-018 SHALL, on *_req while that port's flag is already set and not yet granted, overwrite the stored address (one outstanding request per port).
REQ-019 SHALL, on *_req while that port is in service, set its pending flag for a new access after the current one.
REQ-020 SHALL implement FSM IDLE -> BUSY -> IDLE.
REQ-021 SHALL in IDLE, at an edge with any flag set, grant one port, clear its flag, load mem_addr, and enter BUSY.
REQ-022 SHALL arbitrate round-robin: if only one flag is set, grant it; if both, grant the port not granted last; last-grant resets to CPU, so the first tie goes to PPU.
REQ-023 SHALL map CPU grants to mem_addr = zero-extended cpu address, and PPU grants to mem_addr = CHR_BASE + ppu address, truncated to ADDR_W (modulo 2^ADDR_W).
REQ-024 SHALL hold mem_req=1 and mem_addr stable for the entire BUSY state; mem_req=0 in IDLE.
REQ-025 SHALL, at an edge in BUSY with mem_ack=1, latch mem_rdata into the granted port's data register, pulse that port's *_ack for exactly the next cycle, and return to IDLE.
REQ-026 SHALL leave the other port's data register and ack unchanged on completion; data outputs hold until that port's next completion.
REQ-027 SHALL ignore mem_ack while in IDLE.
REQ-028 SHALL have latency: req sampled at edge N -> mem_req high after edge N+1 (if idle and granted) -> mem_ack at edge M>=N+2 -> *_ack high during cycle after M; minimum 3 cycles req-to-ack.
REQ-029 SHALL re-enter BUSY no earlier than one IDLE cycle after completion (mem_req low for at least one cycle between accesses).
REQ-030 SHALL accept *_req at the same edge as that port's completion, setting pending; cpu_req and ppu_req on the same edge both set their flags.

Reset
REQ-031 SHALL on RST=1 immediately force: FSM=IDLE, mem_req=0, mem_addr=0, both flags=0, cpu_ack=ppu_ack=0, cpu_data=ppu_data=0, last-grant=CPU.
REQ-032 SHALL discard any in-flight access on reset; a mem_ack arriving after reset release with FSM IDLE is ignored.

Verification
REQ-033 Single CPU read: cpu_req, cpu_addr='h1234, memory acks after 2 cycles with 'hA5 -> mem_addr='h1234, cpu_data='hA5, one cpu_ack pulse, ppu_ack stays 0.
REQ-034 Single PPU read: ppu_addr='h1FFF -> mem_addr='h9FFF; with CHR_BASE='hF000, ADDR_W=16 -> mem_addr='h0FFF (wrap).
REQ-035 Simultaneous cpu_req/ppu_req after reset -> PPU served first, CPU second; next simultaneous pair -> PPU first again (last-grant=CPU), with mem_req low for one cycle between grants.
REQ-036 Second cpu_req with cpu_addr='h0002 while the first (cpu_addr='h0001) is still pending ungranted -> only one access, mem_addr='h0002, one cpu_ack.
REQ-037 RST pulse during BUSY, then mem_ack asserted -> mem_req drops asynchronously, no *_ack, data registers=0.
